// File: rtl/flp_adder_pipe_if.sv
// Operand, result and handshake bundle for flp_adder_pipe.
// slave  : adder side (takes operands, produces results).
// master : producer/consumer side driving the adder.
interface flp_adder_pipe_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic              mode;       // 0 = add op1+op2, 1 = accumulate op1
   logic              acc_clr;
   logic [EXP_W-1:0]  exp1;
   logic [EXP_W-1:0]  exp2;
   logic [MANT_W-1:0] mant1;
   logic [MANT_W-1:0] mant2;
   logic              out_valid;
   logic              out_ready;
   logic [EXP_W:0]    exp;
   logic [MANT_W-1:0] mant;
   logic              sat;

   modport slave (
      input  in_valid, mode, acc_clr, exp1, exp2, mant1, mant2, out_ready,
      output in_ready, out_valid, exp, mant, sat
   );

   modport master (
      output in_valid, mode, acc_clr, exp1, exp2, mant1, mant2, out_ready,
      input  in_ready, out_valid, exp, mant, sat
   );
endinterface

// File: rtl/flp_adder_pipe.sv
// Unsigned float adder/accumulator, value (2^MANT_W + m) * 2^e, no special encodings.
// Latency 3 cycles accept-to-out_valid; add ops one per cycle, accumulate ops one per 3 cycles.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready.
// Ports: clk, rst_n (async, active-low); bus (slave) carries in_valid/in_ready, mode, acc_clr,
//        exp1/mant1, exp2/mant2, out_valid/out_ready, exp (EXP_W+1 bits), mant, sat.
module flp_adder_pipe #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 8
) (
   input logic            clk,
   input logic            rst_n,
   flp_adder_pipe_if.slave bus
);
   localparam int E1 = EXP_W + 1;   // result / accumulator exponent width
   localparam int SW = MANT_W + 1;  // significand including the hidden one

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic              adv;

   // accumulator state
   logic [E1-1:0]     acc_exp;
   logic [MANT_W-1:0] acc_mant;
   logic              acc_empty;
   logic              sat_q;

   // S1: operand select, compare/swap, exponent difference
   logic              empty_eff;
   logic              solo;
   logic [E1-1:0]     a_exp, b_exp;
   logic [MANT_W-1:0] a_mant, b_mant;
   logic              swap;

   logic              s1_vld, s1_mode, s1_solo;
   logic [E1-1:0]     s1_exp, s1_diff;
   logic [SW-1:0]     s1_siga, s1_sigb;

   // S2: align and add
   logic [SW-1:0]     addend;
   logic [SW:0]       sum;

   logic              s2_vld, s2_mode;
   logic [E1-1:0]     s2_exp;
   logic [SW:0]       s2_sum;

   // S3: normalise
   logic              carry;
   logic              ovf;
   logic [E1-1:0]     exp_inc;
   logic              res_sat;
   logic [E1-1:0]     res_exp;
   logic [MANT_W-1:0] res_mant;

   // The whole pipe moves together; only a held result blocks it.
   assign adv = ~(bus.out_valid & ~bus.out_ready);

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // BUSY covers an accumulate between accept and its write-back, so the
   // next accumulate always reads an up-to-date accumulator.
   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = adv;
            if (adv && bus.in_valid && bus.mode) state_d = BUSY;
         end
         BUSY: begin
            if (adv && s2_vld && s2_mode) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- S1 ----------------
   always_comb begin
      // a clear in the accept cycle wins over the stored accumulator
      empty_eff = acc_empty | bus.acc_clr;
      solo      = bus.mode & empty_eff;
      if (bus.mode && !empty_eff) begin
         a_exp  = acc_exp;
         a_mant = acc_mant;
      end else begin
         a_exp  = {1'b0, bus.exp1};
         a_mant = bus.mant1;
      end
      if (bus.mode) begin
         b_exp  = {1'b0, bus.exp1};
         b_mant = bus.mant1;
      end else begin
         b_exp  = {1'b0, bus.exp2};
         b_mant = bus.mant2;
      end
      swap = b_exp > a_exp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_mode <= 1'b0;
         s1_solo <= 1'b0;
         s1_exp  <= '0;
         s1_diff <= '0;
         s1_siga <= '0;
         s1_sigb <= '0;
      end else if (adv) begin
         s1_vld <= bus.in_valid & bus.in_ready;
         if (bus.in_valid && bus.in_ready) begin
            s1_mode <= bus.mode;
            s1_solo <= solo;
            if (swap) begin
               s1_exp  <= b_exp;
               s1_diff <= b_exp - a_exp;
               s1_siga <= {1'b1, b_mant};
               s1_sigb <= {1'b1, a_mant};
            end else begin
               s1_exp  <= a_exp;
               s1_diff <= a_exp - b_exp;
               s1_siga <= {1'b1, a_mant};
               s1_sigb <= {1'b1, b_mant};
            end
         end
      end
   end

   // ---------------- S2 ----------------
   always_comb begin
      // a shift of MANT_W+1 or more leaves nothing of the smaller operand
      if (s1_solo || (32'(s1_diff) >= MANT_W + 1)) addend = '0;
      else                                           addend = s1_sigb >> s1_diff;
      sum = {1'b0, s1_siga} + {1'b0, addend};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_mode <= 1'b0;
         s2_exp  <= '0;
         s2_sum  <= '0;
      end else if (adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_mode <= s1_mode;
            s2_exp  <= s1_exp;
            s2_sum  <= sum;
         end
      end
   end

   // ---------------- S3 ----------------
   always_comb begin
      carry          = s2_sum[SW];
      {ovf, exp_inc} = {1'b0, s2_exp} + {{E1{1'b0}}, carry};
      // add-mode exponents are zero-extended, so only accumulates can wrap
      res_sat        = s2_mode & ovf;
      if (res_sat) begin
         res_exp  = '1;
         res_mant = '1;
      end else begin
         res_exp  = exp_inc;
         res_mant = carry ? s2_sum[MANT_W:1] : s2_sum[MANT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.exp       <= '0;
         bus.mant      <= '0;
         acc_exp       <= '0;
         acc_mant      <= '0;
         acc_empty     <= 1'b1;
         sat_q         <= 1'b0;
      end else begin
         if (adv) begin
            bus.out_valid <= s2_vld;
            if (s2_vld) begin
               bus.exp  <= res_exp;
               bus.mant <= res_mant;
            end
         end
         // in_ready implies IDLE, so a clear never races an accumulate write-back
         if (bus.in_ready && bus.acc_clr) begin
            acc_empty <= 1'b1;
            sat_q     <= 1'b0;
         end
         if (adv && s2_vld && s2_mode) begin
            acc_exp   <= res_exp;
            acc_mant  <= res_mant;
            acc_empty <= 1'b0;
            if (res_sat) sat_q <= 1'b1;
         end
      end
   end

   assign bus.sat = sat_q;

endmodule

// File: doc/flp_adder_pipe.md
FLP_ADDER_PIPE -- requirements
Module: flp_adder_pipe

Interface
REQ-001 Parameter EXP_W, default 8, operand exponent width.
REQ-002 Parameter MANT_W, default 8, operand stored-mantissa width; hidden leading one implied.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair/accumulate request present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 mode  input  1  0 = add exp1/mant1 + exp2/mant2; 1 = accumulate exp1/mant1 into accumulator.
REQ-008 acc_clr  input  1  empty the accumulator, clear sat; sampled only while in_ready=1.
REQ-009 exp1, exp2  input  EXP_W  operand exponents.
REQ-010 mant1, mant2  input  MANT_W  operand stored mantissas.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 exp  output  EXP_W+1  result exponent.
REQ-014 mant  output  MANT_W  result stored mantissa.
REQ-015 sat  output  1  sticky accumulator saturation flag.

Function
REQ-016 Value of (e,m) SHALL be (2^MANT_W + m) * 2^e, unsigned, no zero/special encodings.
REQ-017 Transfer in SHALL occur on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-018 Pipeline SHALL be 3 stages: S1 compare/swap, exponent difference; S2 align smaller significand by right shift (truncating), add; S3 normalise, register outputs.
REQ-019 Latency SHALL be 3 cycles, input handshake edge to out_valid, when not stalled.
REQ-020 Stall = out_valid & ~out_ready; while stalled all stages hold, outputs stable, in_ready=0.
REQ-021 Add mode throughput SHALL be one transfer per cycle when unstalled.
REQ-022 Difference >= MANT_W+1 SHALL contribute 0 from the smaller operand.
REQ-023 Sum >= 2^(MANT_W+1) SHALL shift right 1 (LSB dropped), exponent +1; otherwise unchanged; exponents zero-extended to EXP_W+1.
REQ-024 Add mode never saturates; accumulator unaffected by add transactions.
REQ-025 Accumulator state: exponent EXP_W+1 bits, mantissa MANT_W bits, empty flag; result = acc + operand1; exp2/mant2 ignored.
REQ-026 Accumulate with accumulator empty SHALL output operand1 unchanged (exponent zero-extended) and load it; otherwise output and load the sum.
REQ-027 Accumulator SHALL be written when the op leaves S3 into the output register.
REQ-028 Control FSM: IDLE (no accumulate in flight) -> BUSY on accepted mode=1 transfer; BUSY -> IDLE when that op reaches the output register; in_ready=0 in BUSY (hazard interlock, max one accumulate per 3 cycles).
REQ-029 Add ops already in flight SHALL continue while an accumulate enters; ordering preserved.
REQ-030 Accumulate exponent overflow past 2^(EXP_W+1)-1 SHALL force exp and mant all-ones, set sat; accumulator holds saturated value.
REQ-031 acc_clr with an accepted accumulate in the same cycle: clear applies first (result = operand1, sat cleared).
REQ-032 acc_clr without accepted transfer SHALL clear immediately; not sampled when in_ready=0.

Reset
REQ-033 rst_n low SHALL asynchronously clear all stage valids, out_valid=0, exp=0, mant=0, sat=0, accumulator empty, FSM IDLE; in_ready=1 after release.
REQ-034 Reset mid-operation SHALL discard all in-flight ops without emitting results.

Verification (MANT_W=8, EXP_W=8)
REQ-035 Add (10,4)+(5,3), out_ready=1 -> 3 cycles later exp=10, mant=12; (20,3)+(15,5) -> 20,11; (30,24)+(25,10) -> 30,32; back-to-back, one result per cycle.
REQ-036 Add (7,0)+(7,0) -> exp=8, mant=0; (255,255)+(255,255) -> exp=256, mant=255; (100,1)+(90,200) -> exp=100, mant=1.
REQ-037 out_ready=0 for 4 cycles during a 3-op burst -> outputs held, in_ready=0, no loss or duplication, order preserved.
REQ-038 acc_clr+accumulate (10,4), then accumulate (5,3) -> results 10,4 then 10,12; in_ready low 2 cycles after each accept.
REQ-039 Accumulate (255,255) repeatedly -> exponent climbs to 511, next overflow gives exp=511, mant=255, sat=1; acc_clr clears sat.
REQ-040 rst_n low with 3 ops in flight -> out_valid=0 immediately, no result after release.
